if_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit RISC pipeline, directly upstream of the decode stage.
- Holds the PC, reads the instruction memory (combinational-read ROM) and assembles one- or two-word instructions.
- Presents each complete instruction, with its immediate word and PC, in a registered IF/ID bundle.
- Decode never sees an opcode word without its immediate.
- Handles stall from the hazard unit, redirect on taken branch, and HLT.

---
 rtl/if_stage.sv | 273 +++++++++++++++++++++++++++
 tb/tb_if_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 16-bit RISC pipeline.
//
// Holds the PC, reads the combinational-read instruction ROM and assembles
// one- or two-word instructions into a registered IF/ID bundle. A word whose
// top two bits are 2'b11 is the opcode word of a two-word instruction. Its
// immediate is the next word in memory. The opcode is parked in op_buf while
// the immediate is fetched, so decode only ever sees the opcode together
// with its immediate.
//
// Priority each cycle: rst > branch_taken > stall > normal fetch.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned     WIDTH      = 16,
    parameter int unsigned     ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter logic [4:0]      HLT_OPCODE = 5'b00001
) (
    input  logic                  clk,
    input  logic                  rst,

    // Instruction memory (combinational read)
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_rd_en,
    input  logic [WIDTH-1:0]      imem_data,

    // Hazard unit / execute stage
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,

    // IF/ID bundle to decode
    output logic [WIDTH-1:0]      if_instr,
    output logic [WIDTH-1:0]      if_imm,
    output logic                  if_imm_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [ADDR_WIDTH-1:0] if_pc_next,
    output logic                  if_valid
);

    // -----------------------------------------------------------------------
    // Types and decode of the word currently on the memory bus
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        HALTED    = 2'd2
    } state_e;

    state_e                state_q, state_d;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0]      op_buf_q, op_buf_d;
    logic [ADDR_WIDTH-1:0] op_pc_q, op_pc_d;

    logic [WIDTH-1:0]      if_instr_q, if_instr_d;
    logic [WIDTH-1:0]      if_imm_q, if_imm_d;
    logic                  if_imm_valid_q, if_imm_valid_d;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [ADDR_WIDTH-1:0] if_pc_next_q, if_pc_next_d;
    logic                  if_valid_q, if_valid_d;

    logic [4:0]            opcode;
    logic                  is_two_word;
    logic                  is_hlt;

    // Per-cycle actions decided by the FSM output logic
    logic                  act_redirect;    // branch_taken wins over everything but rst
    logic                  act_emit_single; // one-word instruction (incl. HLT) to IF/ID
    logic                  act_capture_op;  // park a two-word opcode in op_buf
    logic                  act_emit_pair;   // opcode + immediate to IF/ID
    logic                  act_bubble;      // drive an empty bundle (halted)
    logic                  act_pc_advance;  // pc <= pc + 1

    assign opcode      = imem_data[WIDTH-1:WIDTH-5];
    assign is_two_word = (imem_data[WIDTH-1:WIDTH-2] == 2'b11);
    assign is_hlt      = (opcode == HLT_OPCODE);

    // Modulo 2^ADDR_WIDTH: all-ones wraps to zero, so a two-word opcode at
    // the top of memory takes its immediate from address 0.
    assign pc_inc      = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // FSM state register (synchronous reset)
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_OP;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default at
    // the top, so no path through the block leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = FETCH_OP;
        end else if (!stall) begin
            unique case (state_q)
                FETCH_OP: begin
                    if (is_hlt) begin
                        state_d = HALTED;
                    end else if (is_two_word) begin
                        state_d = FETCH_IMM;
                    end
                end
                FETCH_IMM: state_d = FETCH_OP;
                HALTED:    state_d = HALTED;
                default:   state_d = FETCH_OP;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM output logic: memory read enable and datapath actions
    // -----------------------------------------------------------------------
    always_comb begin
        imem_rd_en      = !rst && !stall && (state_q != HALTED);
        act_redirect    = 1'b0;
        act_emit_single = 1'b0;
        act_capture_op  = 1'b0;
        act_emit_pair   = 1'b0;
        act_bubble      = 1'b0;
        act_pc_advance  = 1'b0;

        if (branch_taken) begin
            act_redirect = 1'b1;
        end else if (!stall) begin
            unique case (state_q)
                FETCH_OP: begin
                    if (is_hlt) begin
                        // HLT is emitted like any one-word instruction but
                        // the PC stays on it.
                        act_emit_single = 1'b1;
                    end else if (is_two_word) begin
                        act_capture_op  = 1'b1;
                        act_pc_advance  = 1'b1;
                    end else begin
                        act_emit_single = 1'b1;
                        act_pc_advance  = 1'b1;
                    end
                end
                FETCH_IMM: begin
                    act_emit_pair  = 1'b1;
                    act_pc_advance = 1'b1;
                end
                HALTED: begin
                    act_bubble = 1'b1;
                end
                default: begin
                    act_bubble = 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next-state: PC, opcode buffer and IF/ID bundle
    // -----------------------------------------------------------------------
    always_comb begin
        // Stall (or no action) holds everything.
        pc_d           = pc_q;
        op_buf_d       = op_buf_q;
        op_pc_d        = op_pc_q;
        if_instr_d     = if_instr_q;
        if_imm_d       = if_imm_q;
        if_imm_valid_d = if_imm_valid_q;
        if_pc_d        = if_pc_q;
        if_pc_next_d   = if_pc_next_q;
        if_valid_d     = if_valid_q;

        if (act_pc_advance) begin
            pc_d = pc_inc;
        end

        if (act_redirect) begin
            // A half-fetched two-word instruction is squashed simply by
            // returning to FETCH_OP; op_buf is never read again.
            pc_d           = branch_target;
            if_valid_d     = 1'b0;
            if_imm_valid_d = 1'b0;
        end

        if (act_emit_single) begin
            if_instr_d     = imem_data;
            if_imm_d       = '0;
            if_imm_valid_d = 1'b0;
            if_pc_d        = pc_q;
            if_pc_next_d   = pc_inc;
            if_valid_d     = 1'b1;
        end

        if (act_capture_op) begin
            // Decode gets a bubble while the immediate is being fetched.
            op_buf_d       = imem_data;
            op_pc_d        = pc_q;
            if_valid_d     = 1'b0;
            if_imm_valid_d = 1'b0;
        end

        if (act_emit_pair) begin
            if_instr_d     = op_buf_q;
            if_imm_d       = imem_data;
            if_imm_valid_d = 1'b1;
            if_pc_d        = op_pc_q;
            if_pc_next_d   = pc_inc;
            if_valid_d     = 1'b1;
        end

        if (act_bubble) begin
            if_valid_d     = 1'b0;
            if_imm_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers (synchronous reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            op_buf_q       <= '0;
            op_pc_q        <= '0;
            if_instr_q     <= '0;
            if_imm_q       <= '0;
            if_imm_valid_q <= 1'b0;
            if_pc_q        <= '0;
            if_pc_next_q   <= '0;
            if_valid_q     <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            op_buf_q       <= op_buf_d;
            op_pc_q        <= op_pc_d;
            if_instr_q     <= if_instr_d;
            if_imm_q       <= if_imm_d;
            if_imm_valid_q <= if_imm_valid_d;
            if_pc_q        <= if_pc_d;
            if_pc_next_q   <= if_pc_next_d;
            if_valid_q     <= if_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign imem_addr    = pc_q;
    assign if_instr     = if_instr_q;
    assign if_imm       = if_imm_q;
    assign if_imm_valid = if_imm_valid_q;
    assign if_pc        = if_pc_q;
    assign if_pc_next   = if_pc_next_q;
    assign if_valid     = if_valid_q;

    // -----------------------------------------------------------------------
    // Bundle invariants: an empty bundle never claims an immediate, and a
    // two-word opcode never reaches decode without its immediate.
    // -----------------------------------------------------------------------
    a_no_imm_without_valid : assert property (
        @(posedge clk) disable iff (rst) (!if_valid_q |-> !if_imm_valid_q));

    a_two_word_has_imm : assert property (
        @(posedge clk) disable iff (rst)
        ((if_valid_q && (if_instr_q[WIDTH-1:WIDTH-2] == 2'b11)) |-> if_imm_valid_q));

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : directed, self-checking bench for if_stage.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, well away from the active edge. The instruction ROM is modelled as a
// full 64K-word array read combinationally at imem_addr.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] if_instr;
    logic [15:0] if_imm;
    logic        if_imm_valid;
    logic [15:0] if_pc;
    logic [15:0] if_pc_next;
    logic        if_valid;

    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rd_en    (imem_rd_en),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_instr      (if_instr),
        .if_imm        (if_imm),
        .if_imm_valid  (if_imm_valid),
        .if_pc         (if_pc),
        .if_pc_next    (if_pc_next),
        .if_valid      (if_valid)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    endtask

    // Two cycles of reset with quiet control inputs, then release.
    task automatic do_reset();
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mem_clear();
        mem[0] = 16'h1800;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        step();
        step();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_checks++; if (if_imm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_imm_valid: got %b want 0", if_imm_valid); end
        n_checks++; if (if_instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", if_instr); end
        n_checks++; if (if_pc_next !== 16'h0000) begin n_fail++; $display("FAIL reset_pc_next: got %h want 0000", if_pc_next); end
        n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", imem_addr); end
        n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", imem_rd_en); end
        rst = 1'b0;
        #1;
        n_checks++; if (imem_rd_en !== 1'b1) begin n_fail++; $display("FAIL release_rd_en: got %b want 1", imem_rd_en); end
    endtask

    task automatic test_one_word();
        mem_clear();
        mem[0] = 16'h1800;
        mem[1] = 16'h1000;
        do_reset();
        step();
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL ow_valid0: got %b want 1", if_valid); end
        n_checks++; if (if_instr !== 16'h1800) begin n_fail++; $display("FAIL ow_instr0: got %h want 1800", if_instr); end
        n_checks++; if (if_pc !== 16'h0000) begin n_fail++; $display("FAIL ow_pc0: got %h want 0000", if_pc); end
        n_checks++; if (if_pc_next !== 16'h0001) begin n_fail++; $display("FAIL ow_pc_next0: got %h want 0001", if_pc_next); end
        n_checks++; if (if_imm_valid !== 1'b0) begin n_fail++; $display("FAIL ow_imm_valid0: got %b want 0", if_imm_valid); end
        step();
        n_checks++; if (if_instr !== 16'h1000) begin n_fail++; $display("FAIL ow_instr1: got %h want 1000", if_instr); end
        n_checks++; if (if_pc !== 16'h0001) begin n_fail++; $display("FAIL ow_pc1: got %h want 0001", if_pc); end
        n_checks++; if (if_pc_next !== 16'h0002) begin n_fail++; $display("FAIL ow_pc_next1: got %h want 0002", if_pc_next); end
    endtask

    task automatic test_two_word();
        mem_clear();
        mem[0] = 16'hC200;
        mem[1] = 16'h1234;
        do_reset();
        step();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL tw_bubble_valid: got %b want 0", if_valid); end
        n_checks++; if (imem_addr !== 16'h0001) begin n_fail++; $display("FAIL tw_pc_imm: got %h want 0001", imem_addr); end
        step();
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL tw_valid: got %b want 1", if_valid); end
        n_checks++; if (if_instr !== 16'hC200) begin n_fail++; $display("FAIL tw_instr: got %h want c200", if_instr); end
        n_checks++; if (if_imm !== 16'h1234) begin n_fail++; $display("FAIL tw_imm: got %h want 1234", if_imm); end
        n_checks++; if (if_imm_valid !== 1'b1) begin n_fail++; $display("FAIL tw_imm_valid: got %b want 1", if_imm_valid); end
        n_checks++; if (if_pc !== 16'h0000) begin n_fail++; $display("FAIL tw_pc: got %h want 0000", if_pc); end
        n_checks++; if (if_pc_next !== 16'h0002) begin n_fail++; $display("FAIL tw_pc_next: got %h want 0002", if_pc_next); end
    endtask

    task automatic test_stall_imm();
        mem_clear();
        mem[0] = 16'hC200;
        mem[1] = 16'h1234;
        do_reset();
        step();                         // now in FETCH_IMM, pc = 1
        stall = 1'b1;
        #1;
        n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL st_rd_en: got %b want 0", imem_rd_en); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (imem_addr !== 16'h0001) begin n_fail++; $display("FAIL st_pc_hold[%0d]: got %h want 0001", i, imem_addr); end
            n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL st_valid_hold[%0d]: got %b want 0", i, if_valid); end
        end
        stall = 1'b0;
        step();
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid_after: got %b want 1", if_valid); end
        n_checks++; if (if_instr !== 16'hC200) begin n_fail++; $display("FAIL st_instr_after: got %h want c200", if_instr); end
        n_checks++; if (if_imm !== 16'h1234) begin n_fail++; $display("FAIL st_imm_after: got %h want 1234", if_imm); end
        n_checks++; if (if_pc_next !== 16'h0002) begin n_fail++; $display("FAIL st_pc_next_after: got %h want 0002", if_pc_next); end
    endtask

    task automatic test_branch_squash();
        mem_clear();
        mem[0]     = 16'hC200;
        mem[1]     = 16'h1234;
        mem[16'h40] = 16'h2222;
        do_reset();
        step();                         // in FETCH_IMM
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        stall         = 1'b1;
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        n_checks++; if (imem_addr !== 16'h0040) begin n_fail++; $display("FAIL br_pc: got %h want 0040", imem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b want 0", if_valid); end
        n_checks++; if (if_imm_valid !== 1'b0) begin n_fail++; $display("FAIL br_imm_valid: got %b want 0", if_imm_valid); end
        step();
        n_checks++; if (if_instr !== 16'h2222) begin n_fail++; $display("FAIL br_target_instr: got %h want 2222", if_instr); end
        n_checks++; if (if_pc !== 16'h0040) begin n_fail++; $display("FAIL br_target_pc: got %h want 0040", if_pc); end
        n_checks++; if (if_imm_valid !== 1'b0) begin n_fail++; $display("FAIL br_target_imm_valid: got %b want 0", if_imm_valid); end
    endtask

    task automatic test_hlt();
        mem_clear();
        mem[0] = 16'h0800;
        mem[5] = 16'h3333;
        do_reset();
        step();
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL hlt_valid: got %b want 1", if_valid); end
        n_checks++; if (if_instr !== 16'h0800) begin n_fail++; $display("FAIL hlt_instr: got %h want 0800", if_instr); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL hlt_idle_valid[%0d]: got %b want 0", i, if_valid); end
            n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL hlt_idle_pc[%0d]: got %h want 0000", i, imem_addr); end
            n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL hlt_idle_rd_en[%0d]: got %b want 0", i, imem_rd_en); end
        end
        branch_taken  = 1'b1;
        branch_target = 16'h0005;
        step();
        branch_taken = 1'b0;
        n_checks++; if (imem_addr !== 16'h0005) begin n_fail++; $display("FAIL hlt_resume_pc: got %h want 0005", imem_addr); end
        n_checks++; if (imem_rd_en !== 1'b1) begin n_fail++; $display("FAIL hlt_resume_rd_en: got %b want 1", imem_rd_en); end
        step();
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL hlt_resume_valid: got %b want 1", if_valid); end
        n_checks++; if (if_instr !== 16'h3333) begin n_fail++; $display("FAIL hlt_resume_instr: got %h want 3333", if_instr); end
        n_checks++; if (if_pc_next !== 16'h0006) begin n_fail++; $display("FAIL hlt_resume_pc_next: got %h want 0006", if_pc_next); end
    endtask

    task automatic test_wrap();
        mem_clear();
        mem[16'hFFFF] = 16'hC000;
        mem[0]        = 16'hBEEF;
        do_reset();
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        step();
        branch_taken = 1'b0;
        n_checks++; if (imem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wr_pc: got %h want ffff", imem_addr); end
        step();
        n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wr_pc_wrap: got %h want 0000", imem_addr); end
        step();
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid: got %b want 1", if_valid); end
        n_checks++; if (if_instr !== 16'hC000) begin n_fail++; $display("FAIL wr_instr: got %h want c000", if_instr); end
        n_checks++; if (if_imm !== 16'hBEEF) begin n_fail++; $display("FAIL wr_imm: got %h want beef", if_imm); end
        n_checks++; if (if_pc !== 16'hFFFF) begin n_fail++; $display("FAIL wr_if_pc: got %h want ffff", if_pc); end
        n_checks++; if (if_pc_next !== 16'h0001) begin n_fail++; $display("FAIL wr_pc_next: got %h want 0001", if_pc_next); end
    endtask

    task automatic test_back_to_back();
        mem_clear();
        mem[0] = 16'h1111;
        mem[1] = 16'hC200;
        mem[2] = 16'hABCD;
        mem[3] = 16'h2222;
        do_reset();
        step();
        n_checks++; if (if_instr !== 16'h1111 || if_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %h/%b want 1111/1", if_instr, if_valid); end
        step();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble: got %b want 0", if_valid); end
        step();
        n_checks++; if (if_instr !== 16'hC200 || if_imm !== 16'hABCD) begin n_fail++; $display("FAIL b2b_pair: got %h/%h want c200/abcd", if_instr, if_imm); end
        n_checks++; if (if_pc !== 16'h0001 || if_pc_next !== 16'h0003) begin n_fail++; $display("FAIL b2b_pair_pc: got %h/%h want 0001/0003", if_pc, if_pc_next); end
        step();
        n_checks++; if (if_instr !== 16'h2222 || if_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_last: got %h/%b want 2222/1", if_instr, if_valid); end
        n_checks++; if (if_imm !== 16'h0000 || if_imm_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_last_imm: got %h/%b want 0000/0", if_imm, if_imm_valid); end
        n_checks++; if (if_pc !== 16'h0003 || if_pc_next !== 16'h0004) begin n_fail++; $display("FAIL b2b_last_pc: got %h/%h want 0003/0004", if_pc, if_pc_next); end
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        test_reset();
        test_one_word();
        test_two_word();
        test_stall_imm();
        test_branch_squash();
        test_hlt();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
